// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM states,
// error codes and memory geometry of the target CPU.
package prog_loader_pkg;

    localparam int DEPTH_MAX = 32;
    localparam int ADDR_W    = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_RUN,
        ST_HALTED,
        ST_ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CSUM = 2'd2;
    localparam logic [1:0] ERR_WDOG = 2'd3;

endpackage

// File: rtl/loader_wdog.sv
// RUN-phase cycle counter for the program loader. Holds at zero while
// clr is high, counts while en is high, and stops at its terminal count
// (WDOG_CYCLES-1), where tc stays asserted.
module loader_wdog #(
    parameter int WDOG_CYCLES = 1024
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CNT_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WDOG_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    assign tc = (cnt == LAST);

    // Count RUN cycles; the value equals the index of the current RUN cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader. Accepts a framed byte stream (length, program
// bytes, checksum), writes the program into the CPU memory, verifies the
// 8-bit additive checksum, then releases CPU reset until the CPU halts.
// Optional RUN watchdog: define PROG_LOADER_WATCHDOG_EN to build it in.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int DEPTH       = DEPTH_MAX,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [7:0]        IN_DATA,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [7:0]        MEM_WDATA,
    output logic              CPU_RST,
    input  logic              CPU_HALT,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic [1:0]        ERR_CODE
);

    localparam logic [7:0] DEPTH_B = 8'(DEPTH);

    state_t          state;
    state_t          state_nx;
    logic [ADDR_W:0] cnt;
    logic [ADDR_W:0] len;
    logic [7:0]      sum;
    logic            accept;
    logic            len_bad;
    logic            last_byte;
    logic            csum_ok;
    logic            wdog_tc;

    assign accept    = IN_VALID & IN_READY;
    assign len_bad   = (IN_DATA == 8'd0) || (IN_DATA > DEPTH_B);
    assign last_byte = ((cnt + (ADDR_W+1)'(1)) == len);
    assign csum_ok   = (IN_DATA == sum);

`ifdef PROG_LOADER_WATCHDOG_EN
    loader_wdog #(
        .WDOG_CYCLES (WDOG_CYCLES)
    ) u_wdog (
        .CLK   (CLK),
        .RST_N (RST_N),
        .clr   (state != ST_RUN),
        .en    (state == ST_RUN),
        .tc    (wdog_tc)
    );
`else
    // No counter in this build: RUN waits for HALT indefinitely.
    assign wdog_tc = 1'b0 && (WDOG_CYCLES > 0);
`endif

    // Next-state decode; HALT has priority over START and the watchdog in RUN.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (START) state_nx = ST_LEN;
            ST_LEN:    if (accept) state_nx = len_bad ? ST_ERROR : ST_DATA;
            ST_DATA:   if (accept && last_byte) state_nx = ST_CSUM;
            ST_CSUM:   if (accept) state_nx = csum_ok ? ST_RUN : ST_ERROR;
            ST_RUN: begin
                if (CPU_HALT)     state_nx = ST_HALTED;
                else if (wdog_tc) state_nx = ST_ERROR;
            end
            ST_HALTED: if (START) state_nx = ST_LEN;
            ST_ERROR:  if (START) state_nx = ST_LEN;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // State register, registered status outputs, frame datapath and memory write port.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ST_IDLE;
            IN_READY  <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
            CPU_RST   <= 1'b1;
            ERR_CODE  <= ERR_NONE;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
            cnt       <= '0;
            len       <= '0;
            sum       <= '0;
        end else begin
            state    <= state_nx;
            IN_READY <= (state_nx == ST_LEN) || (state_nx == ST_DATA) || (state_nx == ST_CSUM);
            BUSY     <= (state_nx == ST_LEN) || (state_nx == ST_DATA) ||
                        (state_nx == ST_CSUM) || (state_nx == ST_RUN);
            DONE     <= (state_nx == ST_HALTED);
            ERR      <= (state_nx == ST_ERROR);
            CPU_RST  <= !((state_nx == ST_RUN) || (state_nx == ST_HALTED));
            MEM_WE   <= 1'b0;
            case (state)
                ST_LEN: begin
                    if (accept) begin
                        if (len_bad) begin
                            ERR_CODE <= ERR_LEN;
                        end else begin
                            len <= IN_DATA[ADDR_W:0];
                            cnt <= '0;
                            sum <= '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        MEM_WE    <= 1'b1;
                        MEM_ADDR  <= cnt[ADDR_W-1:0];
                        MEM_WDATA <= IN_DATA;
                        cnt       <= cnt + (ADDR_W+1)'(1);
                        sum       <= sum + IN_DATA;
                    end
                end
                ST_CSUM: begin
                    if (accept && !csum_ok) ERR_CODE <= ERR_CSUM;
                end
                ST_RUN: begin
                    if (!CPU_HALT && wdog_tc) ERR_CODE <= ERR_WDOG;
                end
                ST_HALTED, ST_ERROR: begin
                    if (START) ERR_CODE <= ERR_NONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: random framed loads checked against
// a frame-level reference model (length rule, modulo-256 sum, write list).
module tb_prog_loader;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       START = 1'b0;
    logic       IN_VALID = 1'b0;
    logic [7:0] IN_DATA = 8'h00;
    logic       CPU_HALT = 1'b0;
    logic       IN_READY, MEM_WE, CPU_RST, BUSY, DONE, ERR;
    logic [4:0] MEM_ADDR;
    logic [7:0] MEM_WDATA;
    logic [1:0] ERR_CODE;

    int checks = 0;
    int errors = 0;

    logic [7:0] dut_mem   [32];
    logic [7:0] model_mem [32];
    logic [7:0] frame_q   [$];
    logic [4:0] wr_addr_q [$];
    logic [7:0] wr_data_q [$];

    prog_loader #(.DEPTH(32), .WDOG_CYCLES(16)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .START     (START),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_DATA   (IN_DATA),
        .MEM_WE    (MEM_WE),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_WDATA (MEM_WDATA),
        .CPU_RST   (CPU_RST),
        .CPU_HALT  (CPU_HALT),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR       (ERR),
        .ERR_CODE  (ERR_CODE)
    );

    always #5 CLK = ~CLK;

    // CPU memory: every cycle with MEM_WE high is one write.
    always @(negedge CLK) begin
        if (MEM_WE === 1'b1) begin
            dut_mem[MEM_ADDR] = MEM_WDATA;
            wr_addr_q.push_back(MEM_ADDR);
            wr_data_q.push_back(MEM_WDATA);
        end
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Reference: 0 = loads and runs, 1 = bad length, 2 = checksum mismatch.
    function automatic int model_code(input int n, input logic [7:0] csum);
        int s;
        if (n < 1 || n > 32) return 1;
        s = 0;
        foreach (frame_q[i]) s = s + int'(frame_q[i]);
        if ((s % 256) != int'(csum)) return 2;
        return 0;
    endfunction

    function automatic logic [7:0] frame_sum();
        int s;
        s = 0;
        foreach (frame_q[i]) s = s + int'(frame_q[i]);
        return 8'(s % 256);
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) begin
            n = $urandom_range(0, 2);
            for (int k = 0; k < n; k++) @(negedge CLK);
        end
        IN_VALID = 1'b1;
        IN_DATA  = b;
        n = 0;
        while (IN_READY !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL send_byte_timeout: in_ready=%b required 1", IN_READY);
        end
        @(negedge CLK);
        IN_VALID = 1'b0;
    endtask

    task automatic run_frame(input int n, input logic [7:0] csum, input bit gaps,
                             input int start_mid, input string tag);
        int  code;
        int  exp_w;
        bit  bad;
        code = model_code(n, csum);
        wr_addr_q.delete();
        wr_data_q.delete();
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        checks++;
        if (BUSY !== 1'b1 || IN_READY !== 1'b1 || CPU_RST !== 1'b1 || ERR !== 1'b0 ||
            DONE !== 1'b0 || ERR_CODE !== 2'd0) begin
            errors++;
            $display("FAIL %s len_entry: busy=%b rdy=%b cpu_rst=%b err=%b done=%b code=%0d required 1 1 1 0 0 0",
                     tag, BUSY, IN_READY, CPU_RST, ERR, DONE, ERR_CODE);
        end
        send_byte(8'(n), gaps);
        if (code != 1) begin
            for (int i = 0; i < n; i++) begin
                if (i == start_mid) START = 1'b1;
                send_byte(frame_q[i], (i == start_mid) ? 1'b0 : gaps);
                START = 1'b0;
            end
            send_byte(csum, gaps);
        end
        checks++;
        if (code == 0) begin
            if (CPU_RST !== 1'b0 || BUSY !== 1'b1 || IN_READY !== 1'b0 || ERR !== 1'b0) begin
                errors++;
                $display("FAIL %s run_entry: cpu_rst=%b busy=%b rdy=%b err=%b required 0 1 0 0",
                         tag, CPU_RST, BUSY, IN_READY, ERR);
            end
        end else begin
            if (ERR !== 1'b1 || ERR_CODE !== 2'(code) || CPU_RST !== 1'b1 || BUSY !== 1'b0) begin
                errors++;
                $display("FAIL %s error_entry: err=%b code=%0d cpu_rst=%b busy=%b required 1 %0d 1 0",
                         tag, ERR, ERR_CODE, CPU_RST, BUSY, code);
            end
        end
        exp_w = (code == 1) ? 0 : n;
        for (int i = 0; i < exp_w; i++) model_mem[i] = frame_q[i];
        checks++;
        bad = (wr_addr_q.size() != exp_w);
        if (!bad) begin
            for (int i = 0; i < exp_w; i++)
                if (wr_addr_q[i] !== 5'(i) || wr_data_q[i] !== frame_q[i]) bad = 1'b1;
        end
        if (bad) begin
            errors++;
            $display("FAIL %s write_sequence: writes=%0d required %0d in address order",
                     tag, wr_addr_q.size(), exp_w);
        end
        checks++;
        bad = 1'b0;
        for (int i = 0; i < 32; i++) if (dut_mem[i] !== model_mem[i]) bad = 1'b1;
        if (bad) begin
            errors++;
            $display("FAIL %s memory_image: contents differ from expected program image", tag);
        end
    endtask

    task automatic run_cpu(input int halt_after, input bit start_in_run,
                           input bit start_with_halt, input string tag);
        for (int k = 0; k < halt_after; k++) begin
            if (start_in_run && k == 0) START = 1'b1;
            @(negedge CLK);
            START = 1'b0;
        end
        checks++;
        if (BUSY !== 1'b1 || CPU_RST !== 1'b0 || DONE !== 1'b0 || IN_READY !== 1'b0) begin
            errors++;
            $display("FAIL %s still_running: busy=%b cpu_rst=%b done=%b rdy=%b required 1 0 0 0",
                     tag, BUSY, CPU_RST, DONE, IN_READY);
        end
        CPU_HALT = 1'b1;
        START    = start_with_halt;
        @(negedge CLK);
        CPU_HALT = 1'b0;
        START    = 1'b0;
        checks++;
        if (DONE !== 1'b1 || ERR !== 1'b0 || CPU_RST !== 1'b0 || BUSY !== 1'b0 || IN_READY !== 1'b0) begin
            errors++;
            $display("FAIL %s halted: done=%b err=%b cpu_rst=%b busy=%b rdy=%b required 1 0 0 0 0",
                     tag, DONE, ERR, CPU_RST, BUSY, IN_READY);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 32; i++) begin
            dut_mem[i]   = 8'h00;
            model_mem[i] = 8'h00;
        end
        repeat (3) @(negedge CLK);
        checks++;
        if (IN_READY !== 1'b0 || MEM_WE !== 1'b0 || MEM_ADDR !== 5'd0 || MEM_WDATA !== 8'd0) begin
            errors++;
            $display("FAIL reset_port: rdy=%b we=%b addr=%0d wdata=%0d required all 0",
                     IN_READY, MEM_WE, MEM_ADDR, MEM_WDATA);
        end
        checks++;
        if (CPU_RST !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b0 || ERR !== 1'b0 || ERR_CODE !== 2'd0) begin
            errors++;
            $display("FAIL reset_status: cpu_rst=%b busy=%b done=%b err=%b code=%0d required 1 0 0 0 0",
                     CPU_RST, BUSY, DONE, ERR, ERR_CODE);
        end
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if (BUSY !== 1'b0 || IN_READY !== 1'b0 || CPU_RST !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b rdy=%b cpu_rst=%b required 0 0 1",
                     BUSY, IN_READY, CPU_RST);
        end
    endtask

    task automatic test_basic();
        frame_q = '{8'hA1, 8'h02, 8'h00};
        run_frame(3, 8'hA3, 1'b0, -1, "basic");
        run_cpu(2, 1'b0, 1'b0, "basic");
    endtask

    task automatic test_bad_csum();
        bit bad;
        frame_q = '{8'hA1, 8'h00};
        run_frame(2, 8'h00, 1'b0, -1, "bad_csum");
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            if (CPU_RST !== 1'b1 || BUSY !== 1'b0 || ERR !== 1'b1 || ERR_CODE !== 2'd2) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL bad_csum_hold: cpu_rst=%b busy=%b err=%b code=%0d required 1 0 1 2",
                     CPU_RST, BUSY, ERR, ERR_CODE);
        end
    endtask

    task automatic test_bad_len();
        frame_q.delete();
        run_frame(0, 8'h00, 1'b0, -1, "len_zero");
        run_frame(33, 8'h00, 1'b0, -1, "len_33");
    endtask

    task automatic test_full_gaps();
        frame_q.delete();
        for (int i = 0; i < 32; i++) frame_q.push_back(8'($urandom_range(0, 255)));
        run_frame(32, frame_sum(), 1'b1, -1, "full32");
        run_cpu($urandom_range(0, 6), 1'b1, 1'b0, "full32");
    endtask

    task automatic test_reset_mid_load();
        frame_q.delete();
        for (int i = 0; i < 10; i++) frame_q.push_back(8'($urandom_range(1, 255)));
        wr_addr_q.delete();
        wr_data_q.delete();
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        send_byte(8'd10, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(frame_q[i], 1'b0);
        IN_VALID = 1'b1;
        IN_DATA  = frame_q[4];
        @(posedge CLK);
        #1;
        RST_N    = 1'b0;
        IN_VALID = 1'b0;
        #1;
        checks++;
        if (CPU_RST !== 1'b1 || IN_READY !== 1'b0 || MEM_WE !== 1'b0 || BUSY !== 1'b0 ||
            DONE !== 1'b0 || ERR !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_load: cpu_rst=%b rdy=%b we=%b busy=%b done=%b err=%b required 1 0 0 0 0 0",
                     CPU_RST, IN_READY, MEM_WE, BUSY, DONE, ERR);
        end
        for (int i = 0; i < 4; i++) model_mem[i] = frame_q[i];
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if (wr_addr_q.size() != 4 || BUSY !== 1'b0 || IN_READY !== 1'b0) begin
            errors++;
            $display("FAIL reset_drops_write: writes=%0d busy=%b rdy=%b required 4 0 0",
                     wr_addr_q.size(), BUSY, IN_READY);
        end
        frame_q.delete();
        for (int i = 0; i < 7; i++) frame_q.push_back(8'($urandom_range(0, 255)));
        run_frame(7, frame_sum(), 1'b1, -1, "after_reset");
        run_cpu(1, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_start_ignored();
        frame_q.delete();
        for (int i = 0; i < 6; i++) frame_q.push_back(8'($urandom_range(0, 255)));
        run_frame(6, frame_sum(), 1'b0, 2, "start_in_data");
        run_cpu(3, 1'b1, 1'b1, "start_with_halt");
    endtask

    task automatic test_random_frames();
        int n;
        logic [7:0] cs;
        for (int t = 0; t < 8; t++) begin
            n = $urandom_range(0, 36);
            frame_q.delete();
            for (int i = 0; i < n; i++) frame_q.push_back(8'($urandom_range(0, 255)));
            cs = frame_sum();
            if ($urandom_range(0, 2) == 0) cs = cs + 8'($urandom_range(1, 255));
            run_frame(n, cs, 1'b1, -1, "random");
            if (model_code(n, cs) == 0) run_cpu($urandom_range(0, 5), 1'b0, 1'b0, "random");
        end
    endtask

`ifdef PROG_LOADER_WATCHDOG_EN
    task automatic test_watchdog();
        int n;
        frame_q = '{8'hE0};
        run_frame(1, 8'hE0, 1'b0, -1, "watchdog");
        n = 0;
        while (CPU_RST === 1'b0 && n < 100) begin
            n++;
            @(negedge CLK);
        end
        checks++;
        if (n != 16 || ERR !== 1'b1 || ERR_CODE !== 2'd3 || CPU_RST !== 1'b1) begin
            errors++;
            $display("FAIL watchdog: run_cycles=%0d err=%b code=%0d cpu_rst=%b required 16 1 3 1",
                     n, ERR, ERR_CODE, CPU_RST);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_bad_csum();
        test_bad_len();
        test_full_gaps();
        test_reset_mid_load();
        test_start_ignored();
        test_random_frames();
`ifdef PROG_LOADER_WATCHDOG_EN
        test_watchdog();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader sitting directly upstream of the 8-bit accumulator CPU. It accepts a framed byte stream over a valid/ready interface, writes the program into the CPU's 32x8 memory through a dedicated write port, and verifies a checksum. It then releases the CPU's synchronous reset and reports completion when the CPU raises HALT.

## Interface
- DEPTH, 32: CPU memory depth in bytes; address width is 5.
- WDOG_CYCLES, 1024: run-cycle limit, used only with the watchdog compiled in.
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- START  input  1  one-cycle pulse; begins a load from IDLE, HALTED or ERROR.
- IN_VALID  input  1  stream byte valid.
- IN_READY  output  1  loader can accept a byte.
- IN_DATA  input  8  stream byte.
- MEM_WE  output  1  CPU memory write strobe.
- MEM_ADDR  output  5  CPU memory write address.
- MEM_WDATA  output  8  CPU memory write data.
- CPU_RST  output  1  drives CPU RST; active-high.
- CPU_HALT  input  1  CPU HALT flag.
- BUSY  output  1  high in LEN, DATA, CSUM and RUN.
- DONE  output  1  high in HALTED.
- ERR  output  1  high in ERROR.
- ERR_CODE  output  2  0 none, 1 bad length, 2 checksum mismatch, 3 watchdog.

## Operation
- Frame format: length byte N, then N program bytes, then one checksum byte. Valid N is 1..DEPTH.
- States:
  - IDLE: START moves to LEN.
  - LEN: N=0 or N>DEPTH goes to ERROR with code 1. Otherwise clear the sum and address, then go to DATA.
  - DATA: each accepted byte is written to the address counter, the address increments and the byte is added to the sum. After N bytes, go to CSUM.
  - CSUM: a byte equal to the sum goes to RUN. Any other byte goes to ERROR with code 2.
  - RUN: CPU_RST is 0. CPU_HALT=1 goes to HALTED.
  - HALTED: DONE is 1 and CPU_RST stays 0.
  - ERROR: CPU_RST is 1.
- Checksum is the 8-bit sum of the program bytes, modulo 256; carries are discarded.
- Memory addresses N..31 are never written and keep their old contents.
- START is ignored in LEN, DATA, CSUM and RUN. From HALTED or ERROR it clears ERR and ERR_CODE, asserts CPU_RST and enters LEN.
- IN_READY is 1 only in LEN, DATA and CSUM.

## Timing
- A byte transfers on a rising edge where IN_VALID and IN_READY are both high. IN_DATA must be held until it is accepted.
- MEM_WE, MEM_ADDR and MEM_WDATA are registered. MEM_WE is high for exactly the one cycle after each accepted DATA byte, so the write lands on the following edge.
- CPU_RST falls in the cycle after the checksum is accepted. The CPU fetches mem[0] on the first RUN cycle.
- CPU_HALT is sampled every RUN cycle, including the first, so a HLT at address 0 reaches HALTED after 1 cycle.
- The load sequence guarantees that CPU_RST has been high for at least one edge before RUN. This clears the CPU's pc.
- Reset values: IN_READY=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, CPU_RST=1, BUSY=0, DONE=0, ERR=0, ERR_CODE=0, state IDLE.
- Reset mid-load: the loader returns to IDLE immediately. Bytes already written stay in memory, and the pending write strobe is dropped.
- N=32: the address reaches 31 on the last byte. The counter never wraps inside a frame.
- START coincident with CPU_HALT in RUN: HALT wins, and START is ignored.

## Configuration
- PROG_LOADER_WATCHDOG_EN defined:
  - A RUN cycle counter runs, starting at 0 on RUN entry.
  - When it reaches WDOG_CYCLES without CPU_HALT, the loader goes to ERROR with code 3 and reasserts CPU_RST on the next cycle.
- Undefined: there is no counter, RUN waits for HALT indefinitely, and code 3 is never produced.

## Structure
- Shared package prog_loader_pkg holds:
  - the state enumeration (IDLE, LEN, DATA, CSUM, RUN, HALTED, ERROR);
  - the ERR_CODE constants;
  - the constants DEPTH_MAX=32 and ADDR_W=5.
- One sub-module, loader_wdog: a cycle counter with clear and enable, and a terminal-count output. It is instantiated only under PROG_LOADER_WATCHDOG_EN.

## Test plan
- Frame 03, A1, 02, 00, checksum A3 -> memory 0..2 written; RUN, then HALT at pc 2 gives DONE=1, ERR=0.
- Frame 02, A1, 00, checksum 00 -> ERR=1, ERR_CODE=2, CPU_RST stays 1, no RUN.
- Length 00, then in a new frame length 21 (hex) -> ERR_CODE=1 both times, no MEM_WE pulses.
- Frame of 32 bytes with IN_VALID toggling randomly -> 32 single-cycle MEM_WE pulses at addresses 0..31, in order.
- RST_N pulled low after 5 DATA bytes -> CPU_RST=1, IN_READY=0, state IDLE; a following valid frame loads correctly.
- With watchdog, WDOG_CYCLES=16, program E0 (JMP 0) -> ERR_CODE=3 after 16 RUN cycles, CPU_RST=1.
